// File: rtl/pwm_dir_gen_pkg.sv
// rtl/pwm_dir_gen_pkg.sv - shared state type, default timing constants and duty clamp
package pwm_dir_gen_pkg;

  localparam int unsigned PERIOD_DEF      = 1000;
  localparam int unsigned DEAD_CYCLES_DEF = 50;
  localparam int unsigned DUTY_MAX_DEF    = 950;
  localparam int unsigned MAG_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } pwm_state_e;

  function automatic logic [MAG_W-1:0] clamp_mag(input logic [MAG_W-1:0] mag,
                                                 input logic [MAG_W-1:0] lim);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/pwm_period_cnt.sv
// rtl/pwm_period_cnt.sv - free-running period counter 0..PERIOD-1, held at 0 while disabled
module pwm_period_cnt
  import pwm_dir_gen_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_DEF,
  parameter int unsigned CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary,
  output logic             period_start
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt      = r_cnt;
  assign boundary = enable && (r_cnt == LAST);
  // Gated by rst_n so the pulse is forced low while reset is held with enable high.
  assign period_start = rst_n && enable && (r_cnt == '0);

endmodule

// File: rtl/pwm_dir_gen.sv
// rtl/pwm_dir_gen.sv - PWM generator with H-bridge direction and dead-time on reversal
module pwm_dir_gen
  import pwm_dir_gen_pkg::*;
#(
  parameter int unsigned PERIOD      = PERIOD_DEF,
  parameter int unsigned DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int unsigned DUTY_MAX    = DUTY_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAG_W-1:0] mag_in,
  input  logic             sign_in,
  input  logic             valid_in,
  input  logic             enable,
  output logic             pwm_out,
  output logic             dir_out,
  output logic             dead_active,
  output logic             period_start
);

  localparam int unsigned      CNT_W     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [MAG_W-1:0] DUTY_LIM  = MAG_W'(DUTY_MAX);

  logic [CNT_W-1:0] w_cnt;
  logic             w_boundary;

  pwm_period_cnt #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cnt          (w_cnt),
    .boundary     (w_boundary),
    .period_start (period_start)
  );

  pwm_state_e       r_state, w_state_nxt;
  logic [MAG_W-1:0] r_pend_duty, r_act_duty, w_cmp_duty;
  logic             r_pend_sign, r_act_sign;
  logic             r_pwm, r_dead, r_dir;
  logic             w_transfer, w_dir_upd, w_sign_diff, w_dead_now, w_pwm_d;

  assign w_sign_diff = (r_pend_sign != r_dir);

  always_comb begin
    w_state_nxt = r_state;
    w_transfer  = 1'b0;
    w_dir_upd   = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_transfer  = 1'b1;
          w_state_nxt = w_sign_diff ? ST_DEAD : ST_RUN;
        end
        ST_RUN: begin
          if (w_boundary) begin
            w_transfer  = 1'b1;
            w_state_nxt = w_sign_diff ? ST_DEAD : ST_RUN;
          end
        end
        ST_DEAD: begin
          if (w_cnt == DEAD_LAST) begin
            w_dir_upd   = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // The IDLE exit cycle is already cnt 0 of the new period, so it compares against
  // the value being transferred and counts as the first dead cycle on a reversal.
  assign w_dead_now = enable && ((r_state == ST_DEAD) || ((r_state == ST_IDLE) && w_sign_diff));
  assign w_cmp_duty = (r_state == ST_IDLE) ? r_pend_duty : r_act_duty;
  assign w_pwm_d    = enable && !w_dead_now && (32'(w_cnt) < 32'(w_cmp_duty));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pend_duty <= '0;
      r_pend_sign <= 1'b0;
      r_act_duty  <= '0;
      r_act_sign  <= 1'b0;
      r_pwm       <= 1'b0;
      r_dead      <= 1'b0;
      r_dir       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pwm   <= w_pwm_d;
      r_dead  <= w_dead_now;
      if (valid_in) begin
        r_pend_duty <= clamp_mag(mag_in, DUTY_LIM);
        r_pend_sign <= sign_in;
      end
      if (w_transfer) begin
        r_act_duty <= r_pend_duty;
        r_act_sign <= r_pend_sign;
      end
      if (w_dir_upd) begin
        r_dir <= r_act_sign;
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign dead_active = r_dead;
  assign dir_out     = r_dir;

endmodule

// File: tb/tb_pwm_dir_gen.sv
// tb/tb_pwm_dir_gen.sv - directed and random stimulus against a per-period behavioural model
module tb_pwm_dir_gen;

  localparam int PER  = 100;
  localparam int DEAD = 5;
  localparam int DMAX = 95;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mag_in;
  logic        sign_in, valid_in, enable;
  logic        pwm_out, dir_out, dead_active, period_start;

  int checks = 0;
  int errors = 0;

  // Model: position in period, active period parameters, pending and staged values.
  int m_on, m_cnt, m_duty, m_dlen, m_sign, m_dir;
  int m_nduty, m_nsign, m_pduty, m_psign;
  int e_pwm, e_dead;
  int hi, dh, guard;

  pwm_dir_gen #(.PERIOD(PER), .DEAD_CYCLES(DEAD), .DUTY_MAX(DMAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mag_in       (mag_in),
    .sign_in      (sign_in),
    .valid_in     (valid_in),
    .enable       (enable),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out),
    .dead_active  (dead_active),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_cnt = 0; m_duty = 0; m_dlen = 0; m_sign = 0; m_dir = 0;
    m_nduty = 0; m_nsign = 0; m_pduty = 0; m_psign = 0;
    e_pwm = 0; e_dead = 0;
  endtask

  task automatic load(input int d, input int s);
    m_duty = d;
    m_sign = s;
    m_dlen = (s != m_dir) ? DEAD : 0;
  endtask

  task automatic cyc(input bit en, input bit vld, input logic [15:0] mag, input bit sgn);
    int k;
    enable = en; valid_in = vld; mag_in = mag; sign_in = sgn;
    #1;
    chk("period_start", period_start, (en && m_cnt == 0));
    if (!en) begin
      e_pwm = 0; e_dead = 0; m_on = 0; m_cnt = 0;
    end else begin
      if (m_on == 0) begin
        load(m_pduty, m_psign);
        m_on = 1;
      end else if (m_cnt == 0) begin
        load(m_nduty, m_nsign);
      end
      k = m_cnt;
      e_dead = (k < m_dlen) ? 1 : 0;
      e_pwm  = (e_dead == 0 && k < m_duty) ? 1 : 0;
      if (m_dlen != 0 && k == m_dlen - 1) m_dir = m_sign;
      if (k == PER - 1) begin
        m_nduty = m_pduty; m_nsign = m_psign; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (vld) begin
      m_pduty = (int'(mag) > DMAX) ? DMAX : int'(mag);
      m_psign = sgn;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("pwm_out", pwm_out, e_pwm);
    chk("dead_active", dead_active, e_dead);
    chk("dir_out", dir_out, m_dir);
    hi += int'(pwm_out);
    dh += int'(dead_active);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; valid_in = 1'b0; mag_in = '0; sign_in = 1'b0;
    model_reset();
    hi = 0; dh = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_dir", dir_out, 0);
    chk("rst_dead", dead_active, 0);
    chk("rst_ps", period_start, 0);
    rst_n = 1'b1;

    // Plain duty 40 forward
    cyc(1, 1, 16'd40, 0);
    repeat (199) cyc(1, 0, 0, 0);
    hi = 0; dh = 0;
    repeat (PER) cyc(1, 0, 0, 0);
    chk("duty40_high", hi, 40);
    chk("duty40_dead", dh, 0);

    // Clamp of full-scale magnitude
    cyc(1, 1, 16'hFFFF, 0);
    repeat (199) cyc(1, 0, 0, 0);
    hi = 0;
    repeat (PER) cyc(1, 0, 0, 0);
    chk("clamp_high", hi, DMAX);

    // Reversal to duty 40 reverse
    cyc(1, 1, 16'd40, 1);
    dh = 0;
    repeat (250) cyc(1, 0, 0, 0);
    chk("rev_dead_len", dh, DEAD);
    chk("rev_dir", dir_out, 1);

    // Strobe landing exactly in the boundary cycle
    guard = 0;
    while (m_cnt != PER - 1 && guard < 2 * PER) begin cyc(1, 0, 0, 0); guard++; end
    chk("bnd_reach", (m_cnt == PER - 1), 1);
    cyc(1, 1, 16'd70, 1);
    hi = 0;
    repeat (PER) cyc(1, 0, 0, 0);
    chk("bnd_old_duty", hi, 40);
    hi = 0;
    repeat (PER) cyc(1, 0, 0, 0);
    chk("bnd_new_duty", hi, 70);

    // Abort a dead-time at cnt 2, then restart with a fresh dead-time
    cyc(1, 1, 16'd30, 0);
    guard = 0;
    while (m_cnt != PER - 1 && guard < 2 * PER) begin cyc(1, 0, 0, 0); guard++; end
    chk("abort_reach", (m_cnt == PER - 1), 1);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("abort_dir", dir_out, 1);
    chk("abort_pwm", pwm_out, 0);
    repeat (4) cyc(0, 0, 0, 0);
    dh = 0;
    repeat (150) cyc(1, 0, 0, 0);
    chk("abort_redead", dh, DEAD);
    chk("abort_newdir", dir_out, 0);

    // Random traffic with occasional enable drops and extreme magnitudes
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] mg;
      case ($urandom_range(0, 5))
        0: mg = 16'd0;
        1: mg = 16'd95;
        2: mg = 16'd96;
        3: mg = 16'hFFFF;
        default: mg = 16'($urandom_range(0, 120));
      endcase
      cyc(($urandom_range(0, 99) < 97), ($urandom_range(0, 99) < 3), mg, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-run
    cyc(1, 1, 16'd60, 0);
    repeat (250) cyc(1, 0, 0, 0);
    guard = 0;
    while (pwm_out !== 1'b1 && guard < PER) begin cyc(1, 0, 0, 0); guard++; end
    chk("rst_pre_pwm", pwm_out, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", pwm_out, 0);
    chk("arst_dir", dir_out, 0);
    chk("arst_dead", dead_active, 0);
    chk("arst_ps", period_start, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    hi = 0;
    repeat (200) cyc(1, 0, 0, 0);
    chk("post_rst_high", hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
